binary_adder: RTL and testbench



---
 rtl/binary_adder_pkg.sv | 9 +
 rtl/binary_adder_full_adder.sv | 24 ++
 rtl/binary_adder.sv | 85 ++++++++
 tb/tb_binary_adder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/binary_adder_pkg.sv
// Shared definitions for the binary_adder block.
// Holds the default operand width used when the top is instantiated without
// an explicit N override.
package binary_adder_pkg;

  // Default operand / sum width in bits.
  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage : binary_adder_pkg

// File: rtl/binary_adder_full_adder.sv
// One-bit full-adder cell, the building block of the ripple-carry chain.
// Ports:
//   a, b  : operand bits
//   cin   : carry in from the next-lower bit
//   s     : sum bit
//   cout  : carry out to the next-higher bit
// Purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic prop_s;

  assign prop_s = a ^ b;
  assign s      = prop_s ^ cin;
  // Generate when both operand bits are set, otherwise pass the incoming carry
  // along when exactly one operand bit is set.
  assign cout   = (a & b) | (cin & prop_s);

endmodule : full_adder

// File: rtl/binary_adder.sv
// N-bit ripple-carry adder with carry-in, carry-out, signed-overflow flag and
// a single registered output stage (latency of one clock, one op per clock).
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset, clears all outputs
//   A, B      : unsigned N-bit operands
//   Cin       : carry into bit 0
//   in_valid  : operands are valid this cycle
//   Sum       : registered low N bits of A+B+Cin
//   Cout      : registered carry out of bit N-1
//   Ovf       : registered two's-complement overflow
//   out_valid : registered copy of in_valid
module binary_adder
  import binary_adder_pkg::*;
#(
  parameter int unsigned N = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         in_valid,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Ovf,
  output logic         out_valid
);

  // carry_s[i] is the carry into bit i; carry_s[N] is the final carry out.
  logic [N:0]   carry_s;
  logic [N-1:0] sum_s;
  logic         ovf_s;

  logic [N-1:0] sum_d,   sum_q;
  logic         cout_d,  cout_q;
  logic         ovf_d,   ovf_q;
  logic         valid_d, valid_q;

  assign carry_s[0] = Cin;

  for (genvar i = 0; i < N; i++) begin : g_chain
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry_s[i]),
      .s    (sum_s[i]),
      .cout (carry_s[i+1])
    );
  end : g_chain

  // Carry into and out of the sign bit disagree exactly when the signed
  // result does not fit. For N = 1 carry_s[0] is Cin, as required.
  assign ovf_s = carry_s[N] ^ carry_s[N-1];

  // Next-state values for the output stage; results load every cycle and
  // consumers qualify them with out_valid.
  always_comb begin
    sum_d   = sum_s;
    cout_d  = carry_s[N];
    ovf_d   = ovf_s;
    valid_d = in_valid;
  end

  // Output register stage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= {N{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;
  assign out_valid = valid_q;

endmodule : binary_adder

// File: tb/tb_binary_adder.sv
// Self-checking bench for binary_adder with N = 4.
module tb_binary_adder;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] a_s;
  logic [N-1:0] b_s;
  logic         cin_s;
  logic         in_valid_s;
  logic [N-1:0] sum_s;
  logic         cout_s;
  logic         ovf_s;
  logic         out_valid_s;

  int n_vec;
  int n_err;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       vld;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
    logic       ovld;
  } vec_t;

  vec_t vecs [12];

  binary_adder #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a_s),
    .B         (b_s),
    .Cin       (cin_s),
    .in_valid  (in_valid_s),
    .Sum       (sum_s),
    .Cout      (cout_s),
    .Ovf       (ovf_s),
    .out_valid (out_valid_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare the full output tuple {out_valid, Ovf, Cout, Sum} against exp.
  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = {out_valid_s, ovf_s, cout_s, sum_s};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got vld=%b ovf=%b cout=%b sum=%b, want vld=%b ovf=%b cout=%b sum=%b",
               name, got[6], got[5], got[4], got[3:0], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  // Drive operands away from the edge, clock once, check just after the edge.
  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic cin,
                       input logic vld, input logic [6:0] exp, input string name);
    a_s = a; b_s = b; cin_s = cin; in_valid_s = vld;
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  // Independent reference: arithmetic sum, overflow from operand/result signs.
  function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic cin, input logic vld);
    logic [4:0] full;
    logic       ov;
    full = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    ov   = (a[3] == b[3]) && (full[3] != a[3]);
    return {vld, ov, full[4], full[3:0]};
  endfunction

  initial begin
    logic [6:0] exp_q;
    n_vec = 0;
    n_err = 0;

    vecs[0]  = '{4'd0,  4'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{4'd3,  4'd5, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{4'd2,  4'd3, 1'b0, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{4'd7,  4'd8, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{4'd9,  4'd6, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{4'd1,  4'd1, 1'b1, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{4'd15, 4'd1, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{4'd4,  4'd4, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{4'd15, 4'd15,1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{4'd6,  4'd1, 1'b0, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{4'd8,  4'd8, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{4'd5,  4'd9, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b1};

    // Reset held with all-ones operands: outputs must stay cleared.
    rst_n = 1'b0;
    a_s = 4'd15; b_s = 4'd15; cin_s = 1'b1; in_valid_s = 1'b1;
    #2;
    check("reset_async", 7'b0000000);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held", 7'b0000000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", 7'b1011111);

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].vld,
            {vecs[i].ovld, vecs[i].ovf, vecs[i].cout, vecs[i].sum},
            $sformatf("vec%0d", i));
    end

    // Back-to-back pipelining, plus inputs moving between edges must not
    // disturb the held outputs.
    for (int i = 0; i < 8; i++) begin
      logic [3:0] pa;
      logic [3:0] pb;
      pa = 4'(i * 3 + 1);
      pb = 4'(15 - i * 2);
      apply(pa, pb, i[0], 1'b1, model(pa, pb, i[0], 1'b1), $sformatf("pipe%0d", i));
    end
    exp_q = model(4'd14, 4'd0, 1'b0, 1'b1);
    apply(4'd14, 4'd0, 1'b0, 1'b1, exp_q, "hold_pre");
    a_s = 4'd9; b_s = 4'd9; cin_s = 1'b1; in_valid_s = 1'b0;
    #2;
    check("hold_between_edges", exp_q);
    @(posedge clk);
    #1;
    check("hold_next_edge", model(4'd9, 4'd9, 1'b1, 1'b0));

    // in_valid 1,0,1 sequence.
    apply(4'd1, 4'd2, 1'b0, 1'b1, model(4'd1, 4'd2, 1'b0, 1'b1), "valid_1");
    apply(4'd3, 4'd4, 1'b0, 1'b0, model(4'd3, 4'd4, 1'b0, 1'b0), "valid_0");
    apply(4'd5, 4'd6, 1'b1, 1'b1, model(4'd5, 4'd6, 1'b1, 1'b1), "valid_1b");

    // Exhaustive sweep with an asynchronous reset pulse between edges.
    for (int c = 0; c < 2; c++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          apply(4'(x), 4'(y), c[0], 1'b1, model(4'(x), 4'(y), c[0], 1'b1),
                $sformatf("sweep_a%0d_b%0d_c%0d", x, y, c));
          if (c == 1 && x == 7 && y == 9) begin
            rst_n = 1'b0;
            #1;
            check("midsweep_reset", 7'b0000000);
            #1;
            rst_n = 1'b1;
            #1;
            check("midsweep_reset_hold", 7'b0000000);
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_binary_adder
